mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Cache-side memory responder: queues line fill / writeback requests and answers
// each one a fixed number of cycles after it reaches the service engine.
module mem_responder #(
  parameter int LINE_SIZE = 64,
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_type,
  output logic [31:0] resp_addr,
  output logic        busy,
  output logic [31:0] fill_count,
  output logic [31:0] wb_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int DLY_W = 8;
  localparam logic [31:0] LINE_MASK = ~32'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [DLY_W-1:0]   delay;
  logic [31:0]        hold_addr;
  logic               hold_type;

  logic [31:0]        q_addr [DEPTH];
  logic               q_type [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;

  logic               push;
  logic               pop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Capacity is judged on pre-edge occupancy, so a same-cycle pop never frees a slot early.
  assign req_ready = (occ != OCC_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (occ != '0);

  assign busy      = (occ != '0) || (state != IDLE);
  assign resp_addr = hold_addr;
  assign resp_type = hold_type;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr & LINE_MASK;
      q_type[wr_ptr] <= req_type;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      delay      <= '0;
      hold_addr  <= '0;
      hold_type  <= 1'b0;
      resp_valid <= 1'b0;
      fill_count <= '0;
      wb_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold_addr <= q_addr[rd_ptr];
            hold_type <= q_type[rd_ptr];
            delay     <= DLY_W'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (delay == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            delay <= delay - DLY_W'(1);
          end
        end
        RESP: begin
          // Returning through IDLE guarantees a low cycle between responses.
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            if (hold_type) wb_count   <= sat_inc(wb_count);
            else           fill_count <= sat_inc(fill_count);
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
